fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage: owns the program counter, issues word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) consumed by decode. It honours StallD/FlushD from the hazard unit and redirects on taken branches/jumps from execute (PCSrcE/PCTargetE), discarding wrong-path responses still in flight.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: fetch constants and the IF/ID payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction word buffer between the memory response port and IF/ID.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty_c,
    output logic                     full_c
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_c     = (count == '0);
    assign full_c      = (count == CW'(DEPTH));
    assign head_data_c = slots[rd_ptr];
    assign do_push     = push && !clear;
    assign do_pop      = pop && !empty_c && !clear;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffering,
// wrong-path drop after redirects, and the IF/ID register feeding decode.
module fetch_unit import riscv_pkg::*; #(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned DW = CW + 4;

    logic [31:0]   pcf;
    logic [31:0]   head_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] drop_cnt;
    logic [31:0]   fifo_head_c;
    logic          fifo_empty_c;
    logic          fifo_full_c;
    logic [SW-1:0] credit_used_c;
    logic          req_fire_c;
    logic          rsp_live_c;
    logic          rsp_drop_c;
    logic          fifo_push_c;
    logic          fifo_pop_c;
    ifid_t         ifid;

    // Credits come from registered counts only; a same-cycle pop frees nothing.
    assign credit_used_c  = SW'(out_cnt) + SW'(fifo_count);
    assign imem_req_valid = !rst && !PCSrcE && (credit_used_c < SW'(FIFO_DEPTH));
    assign imem_addr      = pcf;
    assign req_fire_c     = imem_req_valid && imem_req_ready;
    assign rsp_drop_c     = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live_c     = imem_rsp_valid && (drop_cnt == '0);
    assign fifo_push_c    = rsp_live_c && !PCSrcE;
    assign fifo_pop_c     = !PCSrcE && !FlushD && !StallD && !fifo_empty_c;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push_c),
        .push_data   (imem_rsp_data),
        .pop         (fifo_pop_c),
        .clear       (PCSrcE),
        .head_data_c (fifo_head_c),
        .count       (fifo_count),
        .empty_c     (fifo_empty_c),
        .full_c      (fifo_full_c)
    );

    // PC, head PC and in-flight bookkeeping; a redirect turns every live request into a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf      <= RESET_PC;
            head_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (PCSrcE) begin
            pcf      <= PCTargetE;
            head_pc  <= PCTargetE;
            out_cnt  <= '0;
            drop_cnt <= drop_cnt + DW'(out_cnt) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire_c) pcf     <= pcf + 32'd4;
            if (fifo_pop_c) head_pc <= head_pc + 32'd4;
            out_cnt <= out_cnt + CW'(req_fire_c) - CW'(rsp_live_c);
            if (rsp_drop_c) drop_cnt <= drop_cnt - DW'(1);
        end
    end

    // IF/ID register: bubbles keep PCD/PCPlus4D and only replace the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
        end else if (PCSrcE || FlushD || (!StallD && fifo_empty_c)) begin
            ifid.instr <= NOP_INSTR;
            ifid.valid <= 1'b0;
        end else if (!StallD) begin
            ifid <= '{instr: fifo_head_c, pc: head_pc, pc_plus4: head_pc + 32'd4, valid: 1'b1};
        end
    end

    assign InstrD   = ifid.instr;
    assign PCD      = ifid.pc;
    assign PCPlus4D = ifid.pc_plus4;
    assign ValidD   = ifid.valid;

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push_c && fifo_full_c && !fifo_pop_c));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fixed-latency memory returning address-as-data, cycle table
// for the stream/stall/flush/ready cases, scoreboard of fetched addresses for ordering.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  flags;    // {stall, flush, ready, exp_valid, exp_req_valid}
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    vec_t        vecs [24];
    mem_t        mq [$];
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_fetch = RPC;
    logic        prev_adv = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic vec_t mk(input logic [4:0] f, input logic [31:0] pc, input logic [31:0] addr);
        vec_t v;
        v.flags    = f;
        v.exp_pc   = pc;
        v.exp_addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A valid IF/ID after an advancing edge is a new instruction: it must be the oldest live fetch.
    task automatic score_outputs();
        logic [31:0] e;
        if (prev_adv && ValidD) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got PCD %h expected no instruction (cycle %0d)", PCD, cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_pcd", PCD, e);
                chk("sb_instr", InstrD, e);
                chk("sb_pcplus4", PCPlus4D, e + 32'd4);
            end
        end
    endtask

    // One clock cycle: entered and left at the falling edge with inputs already set.
    task automatic run_cycle();
        score_outputs();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (rst) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr;
            void'(mq.pop_front());
        end
        #3;
        if (prev_pend) chk("addr_stable", imem_addr, prev_addr);
        if (!rst && imem_req_valid && imem_req_ready) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            mq.push_back('{imem_addr, cyc + lat});
            sb.push_back(imem_addr);
            exp_fetch = imem_addr + 32'd4;
        end
        if (rst) begin
            sb.delete();
            exp_fetch = RPC;
        end else if (PCSrcE) begin
            sb.delete();
            exp_fetch = PCTargetE;
        end
        prev_pend = imem_req_valid && !imem_req_ready;
        prev_addr = imem_addr;
        prev_adv  = !rst && !PCSrcE && !FlushD && !StallD;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_validd"}, ValidD, 1'b0);
        chk({tag, "_instrd"}, InstrD, NOP_INSTR);
        chk({tag, "_pcd"}, PCD, 32'h0);
        chk({tag, "_pcplus4d"}, PCPlus4D, 32'h0);
        chk1({tag, "_reqvalid"}, imem_req_valid, 1'b0);
        chk({tag, "_addr"}, imem_addr, RPC);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ValidD && prev_adv) found = 1'b1;
            else run_cycle();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: no ValidD within 20 cycles, expected PCD %h", name, exp_pc);
        end else begin
            chk(name, PCD, exp_pc);
        end
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Cycle 0 is the first cycle with rst low; IF/ID is first loaded at the end of cycle 2.
        vecs[0]  = mk(5'b00101, 32'd0,  32'd0);
        vecs[1]  = mk(5'b00101, 32'd0,  32'd4);
        vecs[2]  = mk(5'b00101, 32'd0,  32'd8);
        vecs[3]  = mk(5'b00111, 32'd0,  32'd12);
        vecs[4]  = mk(5'b00111, 32'd4,  32'd16);
        vecs[5]  = mk(5'b10111, 32'd8,  32'd20);
        vecs[6]  = mk(5'b10111, 32'd8,  32'd24);
        vecs[7]  = mk(5'b10110, 32'd8,  32'd28);
        vecs[8]  = mk(5'b00110, 32'd8,  32'd28);
        vecs[9]  = mk(5'b00111, 32'd12, 32'd28);
        vecs[10] = mk(5'b00111, 32'd16, 32'd32);
        vecs[11] = mk(5'b00111, 32'd20, 32'd36);
        vecs[12] = mk(5'b01111, 32'd24, 32'd40);
        vecs[13] = mk(5'b00100, 32'd24, 32'd44);
        vecs[14] = mk(5'b00111, 32'd28, 32'd44);
        vecs[15] = mk(5'b00011, 32'd32, 32'd48);
        vecs[16] = mk(5'b00011, 32'd36, 32'd48);
        vecs[17] = mk(5'b00011, 32'd40, 32'd48);
        vecs[18] = mk(5'b00011, 32'd44, 32'd48);
        vecs[19] = mk(5'b00101, 32'd44, 32'd48);
        vecs[20] = mk(5'b00101, 32'd44, 32'd52);
        vecs[21] = mk(5'b00101, 32'd44, 32'd56);
        vecs[22] = mk(5'b00111, 32'd48, 32'd60);
        vecs[23] = mk(5'b00111, 32'd52, 32'd64);

        @(negedge clk);
        run_cycle();
        run_cycle();
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            StallD         = vecs[i].flags[4];
            FlushD         = vecs[i].flags[3];
            imem_req_ready = vecs[i].flags[2];
            #1;
            chk1($sformatf("row%0d_validd", i), ValidD, vecs[i].flags[1]);
            chk($sformatf("row%0d_pcd", i), PCD, vecs[i].exp_pc);
            chk($sformatf("row%0d_pcplus4d", i), PCPlus4D,
                (vecs[i].flags[1] || vecs[i].exp_pc != 32'h0) ? vecs[i].exp_pc + 32'd4 : 32'h0);
            chk($sformatf("row%0d_instrd", i), InstrD, vecs[i].flags[1] ? vecs[i].exp_pc : NOP_INSTR);
            chk1($sformatf("row%0d_reqvalid", i), imem_req_valid, vecs[i].flags[0]);
            chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
            run_cycle();
        end

        // Reset in the middle of a running stream, then refetch from RESET_PC.
        StallD = 1'b0; FlushD = 1'b0; imem_req_ready = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check_reset("midrst");
        rst = 1'b0;
        wait_valid("midrst_first_pcd", RPC);
        repeat (6) run_cycle();

        // Redirect with two words in flight on a 3-cycle memory.
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        lat = 3;
        run_cycle();
        run_cycle();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
        #1;
        chk1("redir_reqvalid", imem_req_valid, 1'b0);
        run_cycle();
        PCSrcE = 1'b0;
        #1;
        chk1("redir_next_reqvalid", imem_req_valid, 1'b1);
        chk("redir_next_addr", imem_addr, 32'h0000_0100);
        chk1("redir_bubble_validd", ValidD, 1'b0);
        chk("redir_bubble_instrd", InstrD, NOP_INSTR);
        wait_valid("redir_target_pcd", 32'h0000_0100);
        repeat (5) run_cycle();

        // Mid-stream redirect near the top of the address space: PC wraps to 0.
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        run_cycle();
        PCSrcE = 1'b0;
        wait_valid("wrap_target_pcd", 32'hFFFF_FFF8);
        repeat (8) run_cycle();

        // Mixed stall/flush/ready/redirect traffic; ordering checked by the scoreboard.
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            StallD         = (r[1:0] == 2'b00);
            FlushD         = (r[4:2] == 3'b000);
            imem_req_ready = (r[6:5] != 2'b00);
            PCSrcE         = (r[10:7] == 4'b0000);
            PCTargetE      = $urandom() & 32'hFFFF_FFFC;
            run_cycle();
        end
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1;
        repeat (20) run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before time 100000");
        $fatal(1);
    end

endmodule
